// File: rtl/portgroup_rx_ctrl_pkg.sv
// Shared types and constants for the portgroup RX sequencer.
package portgroup_rx_pkg;

  // Sequencer occupancy state: OFF while disabled, otherwise the number of filled slots.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    EMPTY = 2'd1,
    HALF  = 2'd2,
    FULL  = 2'd3
  } rx_state_t;

  localparam int DROPCNT_W = 8;

endpackage

// File: rtl/portgroup_rx_ctrl_if.sv
// Bus/stream bundle between the RX source and register file and the portgroup RX sequencer.
// master: drives the RX stream and bus strobes; slave: the sequencer itself.
interface portgroup_rx_ctrl_if #(
  parameter int width_p = 32
);
  import portgroup_rx_pkg::*;

  logic                 regf_ctrl_ena_rval_i;
  logic                 rx_valid_i;
  logic [width_p-1:0]   rx_data_i;
  logic                 regf_rx_data0_rd_i;
  logic                 regf_rx_data1_rd_i;
  logic                 ovfl_clr_i;
  logic [width_p-1:0]   regf_rx_data0_rbus_o;
  logic [width_p-1:0]   regf_rx_data1_rbus_o;
  logic [1:0]           rx_avail_o;
  logic                 ovfl_o;
  logic                 irq_o;
  logic [DROPCNT_W-1:0] drop_cnt_o;

  modport master (
    output regf_ctrl_ena_rval_i, rx_valid_i, rx_data_i,
           regf_rx_data0_rd_i, regf_rx_data1_rd_i, ovfl_clr_i,
    input  regf_rx_data0_rbus_o, regf_rx_data1_rbus_o, rx_avail_o,
           ovfl_o, irq_o, drop_cnt_o
  );

  modport slave (
    input  regf_ctrl_ena_rval_i, rx_valid_i, rx_data_i,
           regf_rx_data0_rd_i, regf_rx_data1_rd_i, ovfl_clr_i,
    output regf_rx_data0_rbus_o, regf_rx_data1_rbus_o, rx_avail_o,
           ovfl_o, irq_o, drop_cnt_o
  );
endinterface

// File: rtl/portgroup_rx_ctrl_slot.sv
// One RX data slot: data register plus valid bit. Set loads data and marks valid;
// clear only drops the valid bit so the bus keeps reading the last word.
module portgroup_rx_slot #(
  parameter int width_p = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_set,
  input  logic               i_clr,
  input  logic [width_p-1:0] i_data,
  output logic [width_p-1:0] o_data,
  output logic               o_vld
);

  logic [width_p-1:0] r_data;
  logic               r_vld;

  // Capture on set; set beats a concurrent clear (a read of an empty slot is meaningless).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (i_set) begin
      r_data <= i_data;
      r_vld  <= 1'b1;
    end else if (i_clr) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule

// File: rtl/portgroup_rx_ctrl.sv
// Portgroup RX sequencer: captures a non-stallable RX word stream into two ping-pong
// slots read back over the register bus, tracks overflow and raises an interrupt while
// data is pending.
// Optional feature macro: PORTGROUP_RX_CTRL_DROPCNT_EN (saturating dropped-word counter).
module portgroup_rx_ctrl
  import portgroup_rx_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                main_clk_i,
  input  logic                main_rst_an_i,
  portgroup_rx_ctrl_if.slave  bus
);

  logic       w_ena;
  logic       w_acc;
  logic       w_wr;
  logic       w_drop;
  logic [1:0] w_avail;
  logic [1:0] w_set;
  logic [1:0] w_clr;
  logic [1:0] w_avail_nxt;
  logic       w_irq_nxt;
  rx_state_t  w_state_nxt;

  logic       r_wp;
  logic       r_ovfl;
  logic       r_irq;
  rx_state_t  r_state;

  assign w_ena  = bus.regf_ctrl_ena_rval_i;
  assign w_acc  = bus.rx_valid_i & w_ena;
  // Write/drop decision uses the pre-read valid bit, so a read of slot wp in the
  // same cycle does not make room for the incoming word.
  assign w_wr   = w_acc & ~w_avail[r_wp];
  assign w_drop = w_acc &  w_avail[r_wp];

  assign w_set[0] = w_wr & ~r_wp;
  assign w_set[1] = w_wr &  r_wp;
  // Disable flushes both valid bits; slot data is retained.
  assign w_clr[0] = ~w_ena | bus.regf_rx_data0_rd_i;
  assign w_clr[1] = ~w_ena | bus.regf_rx_data1_rd_i;

  portgroup_rx_slot #(.width_p(width_p)) u_slot0 (
    .i_clk   (main_clk_i),
    .i_rst_n (main_rst_an_i),
    .i_set   (w_set[0]),
    .i_clr   (w_clr[0]),
    .i_data  (bus.rx_data_i),
    .o_data  (bus.regf_rx_data0_rbus_o),
    .o_vld   (w_avail[0])
  );

  portgroup_rx_slot #(.width_p(width_p)) u_slot1 (
    .i_clk   (main_clk_i),
    .i_rst_n (main_rst_an_i),
    .i_set   (w_set[1]),
    .i_clr   (w_clr[1]),
    .i_data  (bus.rx_data_i),
    .o_data  (bus.regf_rx_data1_rbus_o),
    .o_vld   (w_avail[1])
  );

  // Write pointer: strict 0,1,0,1 order; parked at slot 0 while disabled.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_wp <= 1'b0;
    end else if (!w_ena) begin
      r_wp <= 1'b0;
    end else if (w_wr) begin
      r_wp <= ~r_wp;
    end
  end

  // Sticky overflow: a new drop wins over a simultaneous clear.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_ovfl <= 1'b0;
    end else if (w_drop) begin
      r_ovfl <= 1'b1;
    end else if (bus.ovfl_clr_i) begin
      r_ovfl <= 1'b0;
    end
  end

  // Occupancy state next-state and interrupt decode.
  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = 1'b0;
    w_avail_nxt = w_set | (w_avail & ~w_clr);
    if (!w_ena) begin
      w_state_nxt = OFF;
    end else begin
      unique case (w_avail_nxt)
        2'b00:   w_state_nxt = EMPTY;
        2'b11:   w_state_nxt = FULL;
        default: w_state_nxt = HALF;
      endcase
    end
    // HALF/FULL imply at least one pending word captured while enabled.
    w_irq_nxt = w_ena & ((r_state == HALF) | (r_state == FULL));
  end

  // State and interrupt registers.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_state <= OFF;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

`ifdef PORTGROUP_RX_CTRL_DROPCNT_EN
  logic [DROPCNT_W-1:0] r_drop_cnt;

  // Saturating dropped-word counter; clear wins over a simultaneous increment.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_drop_cnt <= '0;
    end else if (bus.ovfl_clr_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROPCNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign bus.drop_cnt_o = r_drop_cnt;
`else
  assign bus.drop_cnt_o = '0;
`endif

  assign bus.rx_avail_o = w_avail;
  assign bus.ovfl_o     = r_ovfl;
  assign bus.irq_o      = r_irq;

endmodule

// File: tb/tb_portgroup_rx_ctrl.sv
// Directed self-checking bench for portgroup_rx_ctrl (default or DROPCNT_EN build).
module tb_portgroup_rx_ctrl;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  portgroup_rx_ctrl_if #(.width_p(W)) bus ();

  portgroup_rx_ctrl #(.width_p(W)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef PORTGROUP_RX_CTRL_DROPCNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.regf_ctrl_ena_rval_i = 1'b0;
    bus.rx_valid_i           = 1'b0;
    bus.rx_data_i            = '0;
    bus.regf_rx_data0_rd_i   = 1'b0;
    bus.regf_rx_data1_rd_i   = 1'b0;
    bus.ovfl_clr_i           = 1'b0;
    step();
    step();
    chk("rst_avail", 32'(bus.rx_avail_o), 32'd0);
    chk("rst_rbus0", bus.regf_rx_data0_rbus_o, 32'd0);
    chk("rst_irq",   32'(bus.irq_o), 32'd0);
    rst_n = 1'b1;

    // Disabled: valid pulses ignored
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'h55;
    step();
    step();
    bus.rx_valid_i = 1'b0;
    chk("off_avail", 32'(bus.rx_avail_o), 32'd0);
    chk("off_rbus0", bus.regf_rx_data0_rbus_o, 32'd0);
    chk("off_ovfl",  32'(bus.ovfl_o), 32'd0);
    chk("off_cnt",   32'(bus.drop_cnt_o), 32'd0);

    // Enable, capture two words
    bus.regf_ctrl_ena_rval_i = 1'b1;
    step();
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'hA1;
    step();
    chk("wr0_rbus0", bus.regf_rx_data0_rbus_o, 32'hA1);
    chk("wr0_avail", 32'(bus.rx_avail_o), 32'd1);
    chk("wr0_irq",   32'(bus.irq_o), 32'd0);
    bus.rx_data_i = 32'hB2;
    step();
    chk("wr1_rbus1", bus.regf_rx_data1_rbus_o, 32'hB2);
    chk("wr1_avail", 32'(bus.rx_avail_o), 32'd3);
    chk("wr1_irq",   32'(bus.irq_o), 32'd1);

    // Full: third word dropped
    bus.rx_data_i = 32'hC3;
    step();
    bus.rx_valid_i = 1'b0;
    chk("drop_ovfl",  32'(bus.ovfl_o), 32'd1);
    chk("drop_rbus0", bus.regf_rx_data0_rbus_o, 32'hA1);
    chk("drop_rbus1", bus.regf_rx_data1_rbus_o, 32'hB2);
    chk("drop_cnt",   32'(bus.drop_cnt_o), cnt_exp(1));

    // Read slot 0, then refill it
    bus.regf_rx_data0_rd_i = 1'b1;
    step();
    bus.regf_rx_data0_rd_i = 1'b0;
    chk("rd0_avail", 32'(bus.rx_avail_o), 32'd2);
    chk("rd0_rbus0", bus.regf_rx_data0_rbus_o, 32'hA1);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'hD4;
    step();
    bus.rx_valid_i = 1'b0;
    chk("d4_rbus0", bus.regf_rx_data0_rbus_o, 32'hD4);
    chk("d4_avail", 32'(bus.rx_avail_o), 32'd3);

    // wp now 1: free slot 1 and write it, pointer returns to 0
    bus.regf_rx_data1_rd_i = 1'b1;
    step();
    bus.regf_rx_data1_rd_i = 1'b0;
    chk("rd1_avail", 32'(bus.rx_avail_o), 32'd1);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'h11;
    step();
    chk("w11_rbus1", bus.regf_rx_data1_rbus_o, 32'h11);

    // Read slot 0 and write to it in the same cycle: dropped, slot freed
    bus.regf_rx_data0_rd_i = 1'b1;
    bus.rx_data_i = 32'h22;
    step();
    bus.regf_rx_data0_rd_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    chk("rdwr_avail", 32'(bus.rx_avail_o), 32'd2);
    chk("rdwr_rbus0", bus.regf_rx_data0_rbus_o, 32'hD4);
    chk("rdwr_cnt",   32'(bus.drop_cnt_o), cnt_exp(2));

    // Clear overflow alone
    bus.ovfl_clr_i = 1'b1;
    step();
    bus.ovfl_clr_i = 1'b0;
    chk("clr_ovfl", 32'(bus.ovfl_o), 32'd0);
    chk("clr_cnt",  32'(bus.drop_cnt_o), 32'd0);

    // Fill slot 0, then 300 drops
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'h33;
    step();
    chk("w33_avail", 32'(bus.rx_avail_o), 32'd3);
    for (int i = 0; i < 300; i++) begin
      bus.rx_data_i = 32'(i);
      step();
    end
    chk("sat_cnt",   32'(bus.drop_cnt_o), cnt_exp(255));
    chk("sat_ovfl",  32'(bus.ovfl_o), 32'd1);
    chk("sat_rbus0", bus.regf_rx_data0_rbus_o, 32'h33);

    // Clear concurrent with drop: flag set wins, counter clear wins
    bus.ovfl_clr_i = 1'b1;
    step();
    bus.ovfl_clr_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    chk("clrdrop_ovfl", 32'(bus.ovfl_o), 32'd1);
    chk("clrdrop_cnt",  32'(bus.drop_cnt_o), 32'd0);

    // Both read strobes free both slots
    bus.regf_rx_data0_rd_i = 1'b1;
    bus.regf_rx_data1_rd_i = 1'b1;
    step();
    bus.regf_rx_data0_rd_i = 1'b0;
    bus.regf_rx_data1_rd_i = 1'b0;
    chk("rd2_avail", 32'(bus.rx_avail_o), 32'd0);

    // wp is 1: refill slot 1 then slot 0
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'h44;
    step();
    bus.rx_data_i  = 32'h55;
    step();
    bus.rx_valid_i = 1'b0;
    chk("refill_rbus1", bus.regf_rx_data1_rbus_o, 32'h44);
    chk("refill_rbus0", bus.regf_rx_data0_rbus_o, 32'h55);
    step();
    chk("refill_irq", 32'(bus.irq_o), 32'd1);

    // Disable while full
    bus.regf_ctrl_ena_rval_i = 1'b0;
    step();
    chk("dis_avail", 32'(bus.rx_avail_o), 32'd0);
    chk("dis_irq",   32'(bus.irq_o), 32'd0);
    chk("dis_rbus0", bus.regf_rx_data0_rbus_o, 32'h55);

    // Re-enable with a word on the same edge: lands in slot 0
    bus.regf_ctrl_ena_rval_i = 1'b1;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'hE5;
    step();
    chk("reen_rbus0", bus.regf_rx_data0_rbus_o, 32'hE5);
    chk("reen_avail", 32'(bus.rx_avail_o), 32'd1);
    chk("reen_rbus1", bus.regf_rx_data1_rbus_o, 32'h44);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_avail", 32'(bus.rx_avail_o), 32'd0);
    chk("arst_rbus0", bus.regf_rx_data0_rbus_o, 32'd0);
    chk("arst_ovfl",  32'(bus.ovfl_o), 32'd0);
    step();
    chk("arst_hold",  32'(bus.rx_avail_o), 32'd0);
    rst_n = 1'b1;
    bus.rx_valid_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
